// File: rtl/blade_cmd_gen.sv
// Steers gameplay's blade toward tracker targets one STEP per frame, keeping a shadow
// of the blade position in lockstep with gameplay's tick, and debounces the blade button.
module blade_cmd_gen #(
    parameter int X_START   = 480,
    parameter int Y_START   = 280,
    parameter int STEP      = 4,
    parameter int DEADBAND  = 4,
    parameter int X_MAX     = 1023,
    parameter int Y_MAX     = 767,
    parameter int STALE_FRM = 30,
    parameter int DEB_CYC   = 650000
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        game_reset,
    input  logic        move_inhibit,
    input  logic [10:0] target_x,
    input  logic [9:0]  target_y,
    input  logic        target_valid,
    output logic        target_ready,
    input  logic        raw_button,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        button,
    output logic [10:0] shadow_x,
    output logic [9:0]  shadow_y,
    output logic        tracking
);

    localparam logic [0:0] S_HOLD  = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;
    localparam int SW = $clog2(STALE_FRM + 1);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic signed [11:0] DB = 12'(DEADBAND);

    logic [0:0]    state;
    logic          pending_full;
    logic [10:0]   pend_x, act_x;
    logic [9:0]    pend_y, act_y;
    logic [SW-1:0] stale, stale_inc;
    logic [DW-1:0] deb_cnt;

    logic          fstart, tick, accept;
    logic [0:0]    nx_state;
    logic [10:0]   nx_tx;
    logic [9:0]    nx_ty;
    logic signed [11:0] dx, dy;
    logic          nx_up, nx_down, nx_left, nx_right;

    // Handshake: a target is taken on valid && ready; ready is simply "pending slot empty".
    assign fstart       = (vcount == 10'd0) && (hcount == 11'd0);
    assign tick         = (vcount == 10'd800) && (hcount == 11'd1030);
    assign target_ready = !pending_full;
    assign accept       = target_valid && target_ready;
    assign tracking     = (state == S_TRACK);
    assign stale_inc    = (stale == SW'(STALE_FRM)) ? stale : stale + SW'(1);

    // Decisions at fstart use the target that will be active after this edge.
    always_comb begin
        nx_state = state;
        nx_tx    = act_x;
        nx_ty    = act_y;
        if (pending_full) begin
            nx_state = S_TRACK;
            nx_tx    = pend_x;
            nx_ty    = pend_y;
        end else if (stale_inc == SW'(STALE_FRM)) begin
            nx_state = S_HOLD;
        end
        dx       = 12'({1'b0, nx_tx}) - 12'({1'b0, shadow_x});
        dy       = 12'({2'b00, nx_ty}) - 12'({2'b00, shadow_y});
        nx_right = (nx_state == S_TRACK) && (dx > DB) &&
                   (({1'b0, shadow_x} + 12'(STEP)) <= 12'(X_MAX));
        nx_left  = (nx_state == S_TRACK) && (dx < -DB) && (shadow_x >= 11'(STEP));
        nx_down  = (nx_state == S_TRACK) && (dy > DB) &&
                   (({2'b00, shadow_y} + 12'(STEP)) <= 12'(Y_MAX));
        nx_up    = (nx_state == S_TRACK) && (dy < -DB) && (shadow_y >= 10'(STEP));
    end

    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            state        <= S_HOLD;
            pending_full <= 1'b0;
            pend_x       <= 11'd0;
            pend_y       <= 10'd0;
            act_x        <= 11'd0;
            act_y        <= 10'd0;
            stale        <= '0;
            shadow_x     <= 11'(X_START);
            shadow_y     <= 10'(Y_START);
            up           <= 1'b0;
            down         <= 1'b0;
            left         <= 1'b0;
            right        <= 1'b0;
        end else begin
            if (accept) begin
                pend_x       <= target_x;
                pend_y       <= target_y;
                pending_full <= 1'b1;
            end
            if (fstart) begin
                if (pending_full) begin
                    act_x        <= pend_x;
                    act_y        <= pend_y;
                    pending_full <= 1'b0;
                    stale        <= '0;
                end else begin
                    stale <= stale_inc;
                end
                state <= nx_state;
                up    <= nx_up;
                down  <= nx_down;
                left  <= nx_left;
                right <= nx_right;
            end
            // Mirrors gameplay's own update at the same tick so the shadow never drifts.
            if (tick) begin
                if (game_reset) begin
                    shadow_x     <= 11'(X_START);
                    shadow_y     <= 10'(Y_START);
                    up           <= 1'b0;
                    down         <= 1'b0;
                    left         <= 1'b0;
                    right        <= 1'b0;
                    state        <= S_HOLD;
                    pending_full <= 1'b0;
                end else if (!move_inhibit) begin
                    shadow_x <= shadow_x + (right ? 11'(STEP) : 11'd0)
                                         - (left  ? 11'(STEP) : 11'd0);
                    shadow_y <= shadow_y + (down  ? 10'(STEP) : 10'd0)
                                         - (up    ? 10'(STEP) : 10'd0);
                end
            end
        end
    end

    // deb_cnt counts consecutive cycles where raw disagrees with button; any agreement
    // (a bounce back) restarts it, so button flips on the (DEB_CYC+1)th differing cycle.
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            deb_cnt <= '0;
            button  <= 1'b0;
        end else if (raw_button == button) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYC)) begin
            button  <= raw_button;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

endmodule

// File: tb/tb_blade_cmd_gen.sv
// Directed bench for blade_cmd_gen: raster events are driven as single-cycle hcount/vcount
// pulses so whole frames take a few clocks.
module tb_blade_cmd_gen;

    localparam int DEB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        game_reset, move_inhibit;
    logic [10:0] target_x;
    logic [9:0]  target_y;
    logic        target_valid, target_ready;
    logic        raw_button;
    logic        up, down, left, right, button, tracking;
    logic [10:0] shadow_x;
    logic [9:0]  shadow_y;
    logic [3:0]  dirs;

    int checks   = 0;
    int failures = 0;

    assign dirs = {up, down, left, right};

    blade_cmd_gen #(.DEB_CYC(DEB)) dut (
        .vclock(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .game_reset(game_reset), .move_inhibit(move_inhibit),
        .target_x(target_x), .target_y(target_y), .target_valid(target_valid),
        .target_ready(target_ready), .raw_button(raw_button),
        .up(up), .down(down), .left(left), .right(right), .button(button),
        .shadow_x(shadow_x), .shadow_y(shadow_y), .tracking(tracking)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Called at a negedge; holds (h,v) across one posedge and returns at the next negedge.
    task automatic pulse_pos(input logic [10:0] h, input logic [9:0] v);
        hcount = h;
        vcount = v;
        @(negedge clk);
        hcount = 11'd5;
        vcount = 10'd5;
    endtask

    task automatic do_fstart();
        pulse_pos(11'd0, 10'd0);
    endtask

    task automatic do_tick();
        pulse_pos(11'd1030, 10'd800);
    endtask

    task automatic send_target(input logic [10:0] x, input logic [9:0] y);
        target_x     = x;
        target_y     = y;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; hcount = 11'd5; vcount = 10'd5; game_reset = 1'b0; move_inhibit = 1'b0;
        target_x = 11'd0; target_y = 10'd0; target_valid = 1'b0; raw_button = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dirs !== 4'b0000) begin failures++; $display("FAIL reset_dirs got=%b exp=0000", dirs); end
        checks++; if (shadow_x !== 11'd480) begin failures++; $display("FAIL reset_shadow_x got=%0d exp=480", shadow_x); end
        checks++; if (shadow_y !== 10'd280) begin failures++; $display("FAIL reset_shadow_y got=%0d exp=280", shadow_y); end
        checks++; if (target_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", target_ready); end
        checks++; if (tracking !== 1'b0 || button !== 1'b0) begin failures++; $display("FAIL reset_trk_btn got=%b%b exp=00", tracking, button); end
    endtask

    task automatic test_track_right();
        send_target(11'd500, 10'd280);
        checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL track_ready_low got=%b exp=0", target_ready); end
        do_fstart();
        checks++; if (tracking !== 1'b1 || target_ready !== 1'b1) begin failures++; $display("FAIL track_state got=%b%b exp=11", tracking, target_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dirs !== 4'b0001) begin failures++; $display("FAIL track_dirs_%0d got=%b exp=0001", i, dirs); end
            do_tick();
            checks++; if (shadow_x !== 11'(484 + 4 * i)) begin failures++; $display("FAIL track_step_%0d got=%0d exp=%0d", i, shadow_x, 484 + 4 * i); end
            do_fstart();
        end
        checks++; if (dirs !== 4'b0000 || tracking !== 1'b1) begin failures++; $display("FAIL track_deadband got=%b trk=%b exp=0000 trk=1", dirs, tracking); end
        do_tick();
        checks++; if (shadow_x !== 11'd496 || shadow_y !== 10'd280) begin failures++; $display("FAIL track_stop got=%0d,%0d exp=496,280", shadow_x, shadow_y); end
    endtask

    task automatic test_valid_held();
        int caps;
        target_x = 11'd100; target_y = 10'd700; target_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            caps = 0;
            for (int c = 0; c < 6; c++) begin
                if (target_valid && target_ready) caps++;
                @(negedge clk);
            end
            checks++; if (caps != 1) begin failures++; $display("FAIL held_caps_%0d got=%0d exp=1", f, caps); end
            checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL held_ready_%0d got=%b exp=0", f, target_ready); end
            do_fstart();
            if (f == 2) target_valid = 1'b0;
            checks++; if (dirs !== 4'b0110) begin failures++; $display("FAIL held_dirs_%0d got=%b exp=0110", f, dirs); end
        end
        do_tick();
        checks++; if (shadow_x !== 11'd492 || shadow_y !== 10'd284) begin failures++; $display("FAIL held_step got=%0d,%0d exp=492,284", shadow_x, shadow_y); end
    endtask

    task automatic test_clamp();
        int over = 0;
        for (int f = 0; f < 150; f++) begin
            send_target(11'd2047, 10'd1023);
            do_fstart();
            do_tick();
            if (shadow_x > 11'd1023 || shadow_y > 10'd767) over++;
        end
        checks++; if (over != 0) begin failures++; $display("FAIL clamp_overrun got=%0d exp=0", over); end
        checks++; if (shadow_x !== 11'd1020 || shadow_y !== 10'd764) begin failures++; $display("FAIL clamp_pos got=%0d,%0d exp=1020,764", shadow_x, shadow_y); end
        checks++; if (dirs !== 4'b0000 || tracking !== 1'b1) begin failures++; $display("FAIL clamp_dirs got=%b trk=%b exp=0000 trk=1", dirs, tracking); end
        send_target(11'd1023, 10'd767);
        do_fstart();
        checks++; if (dirs !== 4'b0000) begin failures++; $display("FAIL clamp_max_dirs got=%b exp=0000", dirs); end
        do_tick();
        checks++; if (shadow_x !== 11'd1020 || shadow_y !== 10'd764) begin failures++; $display("FAIL clamp_hold got=%0d,%0d exp=1020,764", shadow_x, shadow_y); end
    endtask

    task automatic test_inhibit_game_reset();
        send_target(11'd600, 10'd280);
        checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL gr_pending got=%b exp=0", target_ready); end
        game_reset = 1'b1;
        do_tick();
        game_reset = 1'b0;
        checks++; if (shadow_x !== 11'd480 || shadow_y !== 10'd280) begin failures++; $display("FAIL gr_shadow got=%0d,%0d exp=480,280", shadow_x, shadow_y); end
        checks++; if (tracking !== 1'b0 || dirs !== 4'b0000 || target_ready !== 1'b1) begin failures++; $display("FAIL gr_state got=trk%b dirs%b rdy%b exp=trk0 dirs0000 rdy1", tracking, dirs, target_ready); end
        send_target(11'd600, 10'd280);
        do_fstart();
        checks++; if (tracking !== 1'b1 || dirs !== 4'b0001) begin failures++; $display("FAIL gr_late_capture got=trk%b dirs%b exp=trk1 dirs0001", tracking, dirs); end
        move_inhibit = 1'b1;
        do_tick();
        move_inhibit = 1'b0;
        checks++; if (shadow_x !== 11'd480) begin failures++; $display("FAIL inhibit_x got=%0d exp=480", shadow_x); end
        do_fstart();
        do_tick();
        checks++; if (shadow_x !== 11'd484) begin failures++; $display("FAIL inhibit_resume got=%0d exp=484", shadow_x); end
    endtask

    task automatic test_stale();
        send_target(11'd600, 10'd280);
        do_fstart();
        repeat (29) do_fstart();
        checks++; if (tracking !== 1'b1 || right !== 1'b1) begin failures++; $display("FAIL stale_29 got=trk%b r%b exp=trk1 r1", tracking, right); end
        do_fstart();
        checks++; if (tracking !== 1'b0 || dirs !== 4'b0000) begin failures++; $display("FAIL stale_30 got=trk%b dirs%b exp=trk0 dirs0000", tracking, dirs); end
    endtask

    task automatic test_mid_reset();
        send_target(11'd700, 10'd300);
        checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL midrst_pending got=%b exp=0", target_ready); end
        #3 reset = 1'b1;
        #4 reset = 1'b0;
        @(negedge clk);
        checks++; if (shadow_x !== 11'd480 || shadow_y !== 10'd280) begin failures++; $display("FAIL midrst_shadow got=%0d,%0d exp=480,280", shadow_x, shadow_y); end
        checks++; if (dirs !== 4'b0000 || target_ready !== 1'b1 || tracking !== 1'b0) begin failures++; $display("FAIL midrst_state got=dirs%b rdy%b trk%b exp=dirs0000 rdy1 trk0", dirs, target_ready, tracking); end
        do_fstart();
        checks++; if (tracking !== 1'b0) begin failures++; $display("FAIL midrst_no_pending got=%b exp=0", tracking); end
    endtask

    task automatic test_button();
        int early = 0;
        for (int i = 0; i < 1000; i++) begin
            raw_button = ((i % 5) < 2);
            @(negedge clk);
            if (button !== 1'b0) early++;
        end
        checks++; if (early != 0) begin failures++; $display("FAIL btn_bounce got=%0d exp=0", early); end
        raw_button = 1'b1;
        repeat (DEB) @(negedge clk);
        checks++; if (button !== 1'b0) begin failures++; $display("FAIL btn_rise_early got=%b exp=0", button); end
        @(negedge clk);
        checks++; if (button !== 1'b1) begin failures++; $display("FAIL btn_rise got=%b exp=1", button); end
        raw_button = 1'b0;
        repeat (DEB) @(negedge clk);
        checks++; if (button !== 1'b1) begin failures++; $display("FAIL btn_fall_early got=%b exp=1", button); end
        @(negedge clk);
        checks++; if (button !== 1'b0) begin failures++; $display("FAIL btn_fall got=%b exp=0", button); end
    endtask

    initial begin
        test_reset();
        test_track_right();
        test_valid_held();
        test_clamp();
        test_inhibit_game_reset();
        test_stale();
        test_mid_reset();
        test_button();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
